// File: rtl/gcm_pkg.sv
// Shared constants and FSM encoding for the GCM receive-side tag checker.
package gcm_pkg;

  localparam int unsigned NB_DATA = 128;

  // GCM reduction constant: x^128 = 1 + x + x^2 + x^7, reflected bit order.
  localparam logic [NB_DATA-1:0] R_X = {8'he1, 120'h0};

  typedef enum logic [2:0] {
    StIdle,
    StAbsorb,
    StLength,
    StWaitTag,
    StDone
  } state_e;

endpackage

// File: rtl/gf_2to128_multiplier.sv
// Combinational GF(2^128) multiplier in GCM bit order (MSB is the x^0 coefficient).
module gf_2to128_multiplier
  import gcm_pkg::*;
#(
  parameter int unsigned NbData = NB_DATA
) (
  input  logic [NbData-1:0] i_x,
  input  logic [NbData-1:0] i_y,
  output logic [NbData-1:0] o_z
);

  logic [NbData-1:0] z;
  logic [NbData-1:0] v;

  always_comb begin
    z = '0;
    v = i_y;
    for (int i = NbData - 1; i >= 0; i--) begin
      if (i_x[i]) begin
        z = z ^ v;
      end
      v = v[0] ? ((v >> 1) ^ R_X) : (v >> 1);
    end
    o_z = z;
  end

endmodule

// File: rtl/gcm_tag_checker.sv
// GCM tag verifier: GHASH over AAD/CT blocks and the length block, then compare
// (GHASH ^ E(K,J0)) against the received tag and emit a one-cycle verdict.
module gcm_tag_checker
  import gcm_pkg::*;
#(
  parameter int unsigned NB_DATA = gcm_pkg::NB_DATA,
  parameter int unsigned NB_LEN  = 64,
  parameter int unsigned NB_TAG  = 128,
  parameter int unsigned NB_CNT  = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_hash_subkey,
  input  logic [NB_DATA-1:0] i_ekj0,
  input  logic [NB_LEN-1:0]  i_aad_len,
  input  logic [NB_LEN-1:0]  i_ct_len,
  input  logic               i_block_valid,
  input  logic [NB_DATA-1:0] i_block,
  output logic               o_block_ready,
  input  logic               i_tag_valid,
  input  logic [NB_TAG-1:0]  i_tag,
  output logic               o_tag_ready,
  output logic               o_done,
  output logic               o_tag_ok,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_ghash
);

  state_e              state_q, state_d;
  logic [NB_DATA-1:0]  y_q, y_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  h_q, h_d;
  logic [NB_DATA-1:0]  ekj0_q, ekj0_d;
  logic [NB_LEN-1:0]   aad_len_q, aad_len_d;
  logic [NB_LEN-1:0]   ct_len_q, ct_len_d;
  logic                ok_q, ok_d;

  logic [NB_DATA-1:0]  mul_x;
  logic [NB_DATA-1:0]  mul_z;
  logic [NB_LEN:0]     aad_ceil;
  logic [NB_LEN:0]     ct_ceil;
  logic [NB_CNT-1:0]   n_blocks;
  logic [NB_DATA-1:0]  tag_full;
  logic [NB_TAG-1:0]   tag_cmp;

  // One extra bit so (len + 127) cannot wrap before the shift.
  assign aad_ceil = {1'b0, i_aad_len} + (NB_LEN + 1)'(127);
  assign ct_ceil  = {1'b0, i_ct_len} + (NB_LEN + 1)'(127);
  assign n_blocks = NB_CNT'(aad_ceil >> 7) + NB_CNT'(ct_ceil >> 7);

  assign tag_full = y_q ^ ekj0_q;
  assign tag_cmp  = tag_full[NB_DATA-1 -: NB_TAG];

  gf_2to128_multiplier #(
    .NbData(NB_DATA)
  ) u_mul (
    .i_x(mul_x),
    .i_y(h_q),
    .o_z(mul_z)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    ekj0_d    = ekj0_q;
    aad_len_d = aad_len_q;
    ct_len_d  = ct_len_q;
    ok_d      = ok_q;
    mul_x     = y_q ^ i_block;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          h_d       = i_hash_subkey;
          ekj0_d    = i_ekj0;
          aad_len_d = i_aad_len;
          ct_len_d  = i_ct_len;
          y_d       = '0;
          cnt_d     = n_blocks;
          state_d   = (n_blocks != '0) ? StAbsorb : StLength;
        end
      end
      StAbsorb: begin
        if (i_block_valid) begin
          y_d   = mul_z;
          cnt_d = cnt_q - NB_CNT'(1);
          if (cnt_q == NB_CNT'(1)) begin
            state_d = StLength;
          end
        end
      end
      StLength: begin
        mul_x   = y_q ^ {aad_len_q, ct_len_q};
        y_d     = mul_z;
        state_d = StWaitTag;
      end
      StWaitTag: begin
        if (i_tag_valid) begin
          ok_d    = (tag_cmp == i_tag);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      y_q       <= '0;
      cnt_q     <= '0;
      h_q       <= '0;
      ekj0_q    <= '0;
      aad_len_q <= '0;
      ct_len_q  <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      ekj0_q    <= ekj0_d;
      aad_len_q <= aad_len_d;
      ct_len_q  <= ct_len_d;
      ok_q      <= ok_d;
    end
  end

  assign o_block_ready = (state_q == StAbsorb);
  assign o_tag_ready   = (state_q == StWaitTag);
  assign o_done        = (state_q == StDone);
  assign o_busy        = (state_q != StIdle);
  assign o_tag_ok      = ok_q;
  assign o_ghash       = y_q;

endmodule

// File: tb/tb_gcm_tag_checker.sv
// Directed bench for gcm_tag_checker: NIST vectors, backpressure, abort and
// back-to-back messages, checked against a polynomial-arithmetic GHASH model.
module tb_gcm_tag_checker;

  localparam logic [127:0] H_TC    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EKJ0_TC = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] CT_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] GH_TC2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] TAG_TC2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [95:0]  T96_TC2 = 96'hab6e47d42cec13bdf53a67b2;
  localparam logic [95:0]  T96_TC1 = 96'h58e2fccefa7e3061367f1d57;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic [127:0] h;
  logic [127:0] ekj0;
  logic [63:0]  aad_len;
  logic [63:0]  ct_len;
  logic         blk_valid;
  logic [127:0] blk;
  logic         tag_valid;
  logic [127:0] tag;
  logic [95:0]  tag96;

  logic         block_ready, tag_ready, done, tag_ok, busy;
  logic [127:0] ghash;
  logic         block_ready96, tag_ready96, done96, tag_ok96, busy96;
  logic [127:0] ghash96;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_ghash_q[$];
  bit           exp_ok_q[$];
  bit           exp_ok96_q[$];
  logic [127:0] msg_blocks[$];

  gcm_tag_checker #(.NB_TAG(128)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_hash_subkey(h), .i_ekj0(ekj0),
    .i_aad_len(aad_len), .i_ct_len(ct_len), .i_block_valid(blk_valid), .i_block(blk),
    .o_block_ready(block_ready), .i_tag_valid(tag_valid), .i_tag(tag),
    .o_tag_ready(tag_ready), .o_done(done), .o_tag_ok(tag_ok), .o_busy(busy),
    .o_ghash(ghash)
  );

  gcm_tag_checker #(.NB_TAG(96)) dut96 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_hash_subkey(h), .i_ekj0(ekj0),
    .i_aad_len(aad_len), .i_ct_len(ct_len), .i_block_valid(blk_valid), .i_block(blk),
    .o_block_ready(block_ready96), .i_tag_valid(tag_valid), .i_tag(tag96),
    .o_tag_ready(tag_ready96), .o_done(done96), .o_tag_ok(tag_ok96), .o_busy(busy96),
    .o_ghash(ghash96)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, expected none (or bound expired)", name);
  endtask

  function automatic logic [127:0] rev(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Carry-less product in natural order, reduced by x^128 = x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] a, b;
    logic [255:0] p;
    a = rev(x);
    b = rev(y);
    p = '0;
    for (int i = 0; i < 128; i++) if (b[i]) p = p ^ ({128'b0, a} << i);
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i]     = 1'b0;
        p[i-121] = ~p[i-121];
        p[i-126] = ~p[i-126];
        p[i-127] = ~p[i-127];
        p[i-128] = ~p[i-128];
      end
    end
    return rev(p[127:0]);
  endfunction

  function automatic logic [127:0] model_ghash(input logic [127:0] hk, input logic [63:0] al,
                                               input logic [63:0] cl);
    logic [127:0] y;
    y = '0;
    foreach (msg_blocks[i]) y = gf_mul(y ^ msg_blocks[i], hk);
    return gf_mul(y ^ {al, cl}, hk);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input logic [127:0] th, input logic [127:0] te, input logic [63:0] al,
                         input logic [63:0] cl, input logic [127:0] t, input logic [95:0] t96,
                         input bit stall);
    logic [127:0] g, f;
    int nb, w;
    g = model_ghash(th, al, cl);
    f = g ^ te;
    exp_ghash_q.push_back(g);
    exp_ok_q.push_back(t == f);
    exp_ok96_q.push_back(t96 == f[127:32]);
    tick();
    h = th; ekj0 = te; aad_len = al; ct_len = cl; start = 1'b1;
    tick();
    // Scramble the config inputs: the DUT must work from its latched copies.
    start = 1'b0; h = '0; ekj0 = '1; aad_len = '0; ct_len = '0;
    nb = msg_blocks.size();
    for (int i = 0; i < nb; i++) begin
      if (stall && i == 0) begin
        for (int k = 0; k < 3; k++) begin
          blk_valid = 1'b0;
          start     = (k == 1);
          tag_valid = (k == 1);
          aad_len   = (k == 1) ? 64'd999 : 64'd0;
          tag = ~t; tag96 = ~t96;
          tick();
        end
        start = 1'b0; tag_valid = 1'b0; aad_len = '0;
      end
      blk_valid = 1'b1;
      blk = msg_blocks[i];
      w = 0;
      @(negedge clk);
      while (!block_ready && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (w >= 50) fail_now("block_ready_timeout");
      tick();
    end
    blk_valid = 1'b0;
    blk = '0;
    @(negedge clk);
    check("length_no_tag_ready", tag_ready, 0);
    check("length_no_block_ready", block_ready, 0);
    check("length_busy", busy, 1);
    @(negedge clk);
    check("wait_tag_latency", tag_ready, 1);
    tag_valid = 1'b1; tag = t; tag96 = t96;
    w = 0;
    while (!tag_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) fail_now("tag_ready_timeout");
    @(posedge clk);
    #1;
    tag_valid = 1'b0;
    @(negedge clk);
    check("done_latency", done, 1);
    check("done96_latency", done96, 1);
    msg_blocks.delete();
  endtask

  // Compare process: o_ghash while waiting for the tag, verdicts on every o_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tag_ready) begin
        if (exp_ghash_q.size() == 0) fail_now("ghash_unexpected");
        else check("ghash_wait_tag", ghash, exp_ghash_q[0]);
      end
      if (done) begin
        if (exp_ghash_q.size() == 0) fail_now("spurious_done");
        else begin
          check("ghash_at_done", ghash, exp_ghash_q.pop_front());
          check("tag_ok", tag_ok, exp_ok_q.pop_front());
        end
      end
      if (done96) begin
        if (exp_ok96_q.size() == 0) fail_now("spurious_done96");
        else check("tag_ok96", tag_ok96, exp_ok96_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tagname);
    check({tagname, "_busy"}, busy, 0);
    check({tagname, "_block_ready"}, block_ready, 0);
    check({tagname, "_tag_ready"}, tag_ready, 0);
    check({tagname, "_done"}, done, 0);
    check({tagname, "_tag_ok"}, tag_ok, 0);
    check({tagname, "_ghash"}, ghash, 0);
    check({tagname, "_tag_ok96"}, tag_ok96, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; h = '0; ekj0 = '0; aad_len = '0; ct_len = '0;
    blk_valid = 1'b0; blk = '0; tag_valid = 1'b0; tag = '0; tag96 = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Pin the model to published NIST values.
    check("model_tc1_ghash", model_ghash(H_TC, 64'd0, 64'd0), 128'h0);
    msg_blocks.push_back(CT_TC2);
    check("model_tc2_ghash", model_ghash(H_TC, 64'd0, 64'd128), GH_TC2);
    check("model_tc2_tag", model_ghash(H_TC, 64'd0, 64'd128) ^ EKJ0_TC, TAG_TC2);
    msg_blocks.delete();

    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd0, EKJ0_TC, T96_TC1, 1'b0);
    check("tc1_ghash_literal", ghash, 128'h0);
    check("tc1_ok_literal", tag_ok, 1);

    msg_blocks.push_back(CT_TC2);
    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd128, TAG_TC2, T96_TC2, 1'b0);
    check("tc2_ghash_literal", ghash, GH_TC2);
    check("tc2_ok_literal", tag_ok, 1);

    msg_blocks.push_back(CT_TC2);
    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd128, TAG_TC2 ^ 128'h1, T96_TC2, 1'b0);
    check("tc2_flip_ok_literal", tag_ok, 0);
    check("tc2_96_ok_literal", tag_ok96, 1);

    msg_blocks.push_back(CT_TC2);
    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd128, TAG_TC2, T96_TC2, 1'b1);
    check("stall_ok_literal", tag_ok, 1);

    // Abort a two-block AAD message after one block.
    tick();
    h = H_TC; ekj0 = EKJ0_TC; aad_len = 64'd256; ct_len = 64'd0; start = 1'b1;
    tick();
    start = 1'b0; blk_valid = 1'b1; blk = 128'h0123456789abcdef0123456789abcdef;
    @(negedge clk);
    check("abort_block_ready", block_ready, 1);
    tick();
    blk_valid = 1'b0;
    @(negedge clk);
    check("abort_still_absorbing", block_ready, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", busy, 0);

    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd0, EKJ0_TC, T96_TC1, 1'b0);

    // Back-to-back: TC2 then TC1 with i_start in the cycle after DONE.
    msg_blocks.push_back(CT_TC2);
    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd128, TAG_TC2, T96_TC2, 1'b0);
    run_msg(H_TC, EKJ0_TC, 64'd0, 64'd0, EKJ0_TC, T96_TC1, 1'b0);
    check("b2b_ok_literal", tag_ok, 1);

    repeat (4) @(negedge clk);
    check("verdicts_drained", exp_ghash_q.size(), 0);
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
